spram_fifo_ctrl: RTL and testbench
==================================

SPRAM_FIFO_CTRL -- requirements
Module: spram_fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 11, RAM address width; RAM depth is 2**ADDR_SIZE words.
REQ-002 SHALL have parameter DATA_SIZE, default 9, word width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  upstream word offered.
REQ-007 in_ready  output  1  word accepted on an edge where in_valid && in_ready.
REQ-008 in_data  input  DATA_SIZE  upstream word.
REQ-009 out_valid  output  1  downstream word available.
REQ-010 out_ready  input  1  word consumed on an edge where out_valid && out_ready.
REQ-011 out_data  output  DATA_SIZE  downstream word, oldest first.
REQ-012 ram_addr  output  ADDR_SIZE  address to the external single-port RAM.
REQ-013 ram_wren  output  1  RAM write enable.
REQ-014 ram_data_in  output  DATA_SIZE  RAM write data.
REQ-015 ram_data_out  input  DATA_SIZE  RAM read data, valid the cycle after the read address is presented.
REQ-016 count  output  ADDR_SIZE+2  total words held: RAM, read in flight and output buffer.
REQ-017 full  output  1  RAM region holds 2**ADDR_SIZE unread words.
REQ-018 empty  output  1  count == 0.

Function
REQ-019 SHALL act as a first-in, first-out queue built over one single-port RAM with 1-cycle registered read latency; exactly one RAM operation (read or write) per cycle.
REQ-020 SHALL keep wr_ptr and rd_ptr (ADDR_SIZE bits, natural wrap at 2**ADDR_SIZE) and ram_cnt (ADDR_SIZE+1 bits, 0..2**ADDR_SIZE).
REQ-021 SHALL keep a 2-entry output buffer (buf_cnt 0..2) and a 1-bit rd_pend flag marking a RAM read in flight.
REQ-022 SHALL issue a read (ram_addr=rd_ptr, ram_wren=0) in any cycle where ram_cnt>0 and buf_cnt+rd_pend, after accounting for an output pop in the same cycle, is less than 2.
REQ-023 SHALL drive in_ready = !full && !read_issue; in_ready SHALL NOT depend on in_valid.
REQ-024 SHALL, on an accepted write, drive ram_addr=wr_ptr, ram_wren=1, ram_data_in=in_data, and increment wr_ptr.
REQ-025 SHALL drive ram_wren=0 in every cycle without an accepted write; ram_addr SHALL hold rd_ptr when idle.
REQ-026 SHALL set rd_pend on the edge ending a read-issue cycle; increment rd_ptr and decrement ram_cnt on that same edge.
REQ-027 SHALL capture ram_data_out into the output buffer on the edge ending the cycle in which rd_pend=1, and clear rd_pend unless a new read was issued.
REQ-028 SHALL drive out_valid = buf_cnt>0 and out_data = oldest buffered word; pop on out_valid && out_ready.
REQ-029 Latency: a word written into an empty queue at edge N SHALL appear on out_valid in the cycle after edge N+2.
REQ-030 Simultaneous push, pop and capture in one cycle SHALL all take effect, with count adjusted by the net change.
REQ-031 full SHALL be ram_cnt == 2**ADDR_SIZE; while full is asserted, in_ready=0 and in_valid SHALL have no effect.
REQ-032 On empty, out_valid=0; out_ready SHALL have no effect.
REQ-033 SHALL preserve order across pointer wrap-around.

Reset
REQ-034 On rst: wr_ptr, rd_ptr, ram_cnt, buf_cnt, rd_pend, count = 0; out_valid=0, in_ready=0 while rst asserted, ram_wren=0, full=0, empty=1.
REQ-035 Reset mid-operation SHALL discard all queued and in-flight words; RAM contents are not cleared.

Structure
REQ-036 Package spram_fifo_pkg SHALL hold ADDR_SIZE/DATA_SIZE defaults and the output-buffer depth constant (2).
REQ-037 The 2-entry output buffer SHALL be a sub-module fifo_out_buf; the RAM is instantiated by the parent, not inside this block.

Verification
REQ-038 Single word: push 9'h1A5 into an empty queue -> ram_wren=1 at addr 0, out_valid after 3 edges with out_data=9'h1A5, then count=0 and empty=1.
REQ-039 Fill: push 2**ADDR_SIZE+2 words with out_ready=0 -> full=1, count=2**ADDR_SIZE+2, in_ready=0; drain -> words 0..N-1 in order.
REQ-040 Streaming: in_valid=1 and out_ready=1 continuously for 5000 words -> output matches input in order with no loss or duplication across pointer wrap.
REQ-041 Backpressure: random out_ready at 30% -> out_data held stable while out_valid && !out_ready; in_ready never 1 in a read-issue cycle.
REQ-042 Reset mid-stream: assert rst with count=7 and a read in flight -> count=0, out_valid=0 immediately; the next pushed word 9'h055 is the first word out.

Source files
------------

// File: rtl/spram_fifo_pkg.sv
// Shared constants for the single-port-RAM FIFO controller.
//   DEFAULT_ADDR_SIZE : default RAM address width (depth = 2**ADDR_SIZE words)
//   DEFAULT_DATA_SIZE : default word width
//   OUT_BUF_DEPTH     : depth of the output skid buffer that hides RAM read latency
package spram_fifo_pkg;
    localparam int DEFAULT_ADDR_SIZE = 11;
    localparam int DEFAULT_DATA_SIZE = 9;
    localparam int OUT_BUF_DEPTH     = 2;
endpackage

// File: rtl/spram_fifo_ctrl_if.sv
// Upstream/downstream word streams of the FIFO controller.
//   in_valid/in_ready/in_data    : upstream stream into the FIFO
//   out_valid/out_ready/out_data : downstream stream out of the FIFO
// Handshake: a word moves on a rising edge where valid && ready. A source
// holds valid and data stable until that edge; ready never depends on valid.
// modport master : the side producing in_* and consuming out_* (the user)
// modport slave  : the FIFO controller itself
interface spram_fifo_ctrl_if
    import spram_fifo_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_SIZE-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_SIZE-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/spram_fifo_ctrl_fifo_out_buf.sv
// Two-entry output buffer that holds words already read from the RAM.
//   clk, rst  : clock, asynchronous active-high reset (discards contents)
//   push      : store push_data (caller guarantees a free entry)
//   push_data : word captured from the RAM read port
//   pop       : remove the oldest word (caller guarantees valid)
//   valid     : at least one word held
//   data      : oldest word
//   cnt       : number of words held (0..2)
module fifo_out_buf
    import spram_fifo_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic                 valid,
    output logic [DATA_SIZE-1:0] data,
    output logic [1:0]           cnt
);
    logic [DATA_SIZE-1:0] mem_q [OUT_BUF_DEPTH];
    logic [DATA_SIZE-1:0] mem_d [OUT_BUF_DEPTH];
    logic                 wr_idx_q, wr_idx_d;
    logic                 rd_idx_q, rd_idx_d;
    logic [1:0]           cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        if (push) begin
            mem_d[wr_idx_q] = push_data;
            wr_idx_d        = ~wr_idx_q;
        end
        if (pop) begin
            rd_idx_d = ~rd_idx_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            cnt_q    <= cnt_d;
        end
    end

    // Data storage needs no reset; cnt_q alone decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign valid = (cnt_q != 2'd0);
    assign data  = mem_q[rd_idx_q];
    assign cnt   = cnt_q;
endmodule

// File: rtl/spram_fifo_ctrl.sv
// FIFO controller over one external single-port RAM with 1-cycle read latency.
// One RAM operation per cycle: reads have priority so the output buffer stays
// primed; writes take the remaining cycles.
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : upstream/downstream word streams (slave modport)
//   ram_addr     : RAM address (write pointer on a write, else read pointer)
//   ram_wren     : RAM write enable
//   ram_data_in  : RAM write data
//   ram_data_out : RAM read data, valid the cycle after the read address
//   count        : words held in RAM + read in flight + output buffer
//   full         : RAM region holds 2**ADDR_SIZE unread words
//   empty        : count == 0
module spram_fifo_ctrl
    import spram_fifo_pkg::*;
#(
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    spram_fifo_ctrl_if.slave     bus,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic                 ram_wren,
    output logic [DATA_SIZE-1:0] ram_data_in,
    input  logic [DATA_SIZE-1:0] ram_data_out,
    output logic [ADDR_SIZE+1:0] count,
    output logic                 full,
    output logic                 empty
);
    localparam logic [ADDR_SIZE:0] RAM_DEPTH = {1'b1, {ADDR_SIZE{1'b0}}};
    localparam logic [2:0]         BUF_DEPTH = 3'(OUT_BUF_DEPTH);

    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_SIZE:0]   ram_cnt_q, ram_cnt_d;
    logic                 rd_pend_q, rd_pend_d;

    logic [1:0] buf_cnt;
    logic       buf_valid;
    logic       pop;
    logic       push;
    logic       read_issue;
    logic       in_ready;
    logic [2:0] buf_level;

    always_comb begin
        pop  = buf_valid && bus.out_ready;
        // Slots already claimed once this cycle's pop is taken into account;
        // the in-flight read will land in the buffer on this edge.
        buf_level  = {1'b0, buf_cnt} - {2'b0, pop} + {2'b0, rd_pend_q};
        read_issue = (ram_cnt_q != '0) && (buf_level < BUF_DEPTH);
        full       = (ram_cnt_q == RAM_DEPTH);
        in_ready   = !rst && !full && !read_issue;
        push       = bus.in_valid && in_ready;
    end

    always_comb begin
        ram_wren    = push;
        ram_addr    = push ? wr_ptr_q : rd_ptr_q;
        ram_data_in = bus.in_data;
        wr_ptr_d    = wr_ptr_q + {{(ADDR_SIZE-1){1'b0}}, push};
        rd_ptr_d    = rd_ptr_q + {{(ADDR_SIZE-1){1'b0}}, read_issue};
        ram_cnt_d   = ram_cnt_q + {{ADDR_SIZE{1'b0}}, push}
                                - {{ADDR_SIZE{1'b0}}, read_issue};
        rd_pend_d   = read_issue;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // RAM read data is captured exactly one cycle after the read was issued.
    fifo_out_buf #(
        .DATA_SIZE (DATA_SIZE)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pend_q),
        .push_data (ram_data_out),
        .pop       (pop),
        .valid     (buf_valid),
        .data      (bus.out_data),
        .cnt       (buf_cnt)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = buf_valid;

    assign count = {1'b0, ram_cnt_q}
                 + {{ADDR_SIZE{1'b0}}, buf_cnt}
                 + {{(ADDR_SIZE+1){1'b0}}, rd_pend_q};
    assign empty = (count == '0);
endmodule

// File: tb/tb_spram_fifo_ctrl.sv
module tb_spram_fifo_ctrl;
    import spram_fifo_pkg::*;

    localparam int AW    = DEFAULT_ADDR_SIZE;
    localparam int DW    = DEFAULT_DATA_SIZE;
    localparam int DEPTH = 1 << AW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spram_fifo_ctrl_if #(.DATA_SIZE(DW)) bus ();

    logic [AW-1:0] ram_addr;
    logic          ram_wren;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;
    logic [AW+1:0] count;
    logic          full;
    logic          empty;

    spram_fifo_ctrl #(
        .ADDR_SIZE (AW),
        .DATA_SIZE (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .ram_addr     (ram_addr),
        .ram_wren     (ram_wren),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    // Single-port RAM with registered read port.
    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] ram_rd_q;
    always @(posedge clk) begin
        if (ram_wren) ram_mem[ram_addr] <= ram_data_in;
        ram_rd_q <= ram_mem[ram_addr];
    end
    assign ram_data_out = ram_rd_q;

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int            pass_cnt  = 0;
    int            total_cnt = 0;
    logic [AW-1:0] exp_wr_ptr;
    logic          prev_hold;
    logic [DW-1:0] prev_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: records accepted words, checks every delivered word in order.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_wr_ptr = '0;
            prev_hold  = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, prev_data);
            end
            check("wren_vs_accept", ram_wren, bus.in_valid && bus.in_ready);
            if (bus.in_valid && bus.in_ready) begin
                check("wr_addr", ram_addr, exp_wr_ptr);
                check("wr_data", ram_data_in, bus.in_data);
                exp_q.push_back(bus.in_data);
                exp_wr_ptr++;
            end
            if (bus.out_valid && bus.out_ready) begin
                check("out_with_words_queued", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("out_data_order", bus.out_data, exp_q.pop_front());
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end at posedge+1.
    task automatic push_word(input logic [DW-1:0] d);
        logic acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int k = 0; k < 64 && !acc; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("push_accepted", acc, 1);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_done", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   i;
        int   cyc;
        logic acc;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_wren", ram_wren, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---- single word, latency ----
        bus.in_valid = 1'b1;
        bus.in_data  = 9'h1A5;
        @(negedge clk);
        check("sw_in_ready", bus.in_ready, 1);
        check("sw_wren", ram_wren, 1);
        check("sw_addr", ram_addr, 0);
        @(posedge clk); #1;          // edge N accepts the word
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("sw_lat_n", bus.out_valid, 0);
        check("sw_count_n", count, 1);
        @(negedge clk);
        check("sw_lat_n1", bus.out_valid, 0);
        @(negedge clk);
        check("sw_lat_n2", bus.out_valid, 1);
        check("sw_data", bus.out_data, 9'h1A5);
        check("sw_count_n2", count, 1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("sw_count_after", count, 0);
        check("sw_empty_after", empty, 1);
        check("sw_out_valid_after", bus.out_valid, 0);

        // ---- fill to full with no consumer ----
        @(posedge clk); #1;
        for (int k = 0; k < DEPTH + 2; k++) push_word(DW'(k));
        @(negedge clk);
        check("fill_full", full, 1);
        check("fill_count", count, DEPTH + 2);
        check("fill_in_ready", bus.in_ready, 0);
        check("fill_empty", empty, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;         // offered while full: must be ignored
        bus.in_data  = 9'h1FF;
        repeat (3) begin
            @(negedge clk);
            check("full_in_ready", bus.in_ready, 0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("full_count_held", count, DEPTH + 2);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_drain(20000);
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("drain_empty", empty, 1);
        check("drain_count", count, 0);
        check("drain_full", full, 0);

        // ---- streaming across pointer wrap ----
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        i   = 0;
        cyc = 0;
        bus.in_data = DW'(5);
        while (i < 5000 && cyc < 40000) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            if (acc) begin
                i++;
                bus.in_data = DW'((i * 37 + 5) % 512);
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("stream_sent", i, 5000);
        wait_drain(2000);
        bus.out_ready = 1'b0;

        // ---- random backpressure ----
        i   = 0;
        cyc = 0;
        while (i < 300 && cyc < 6000) begin
            bus.out_ready = ($urandom_range(0, 99) < 30);
            if (!bus.in_valid && $urandom_range(0, 99) < 70) begin
                bus.in_valid = 1'b1;
                bus.in_data  = DW'($urandom_range(0, 511));
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) begin
                i++;
                bus.in_valid = 1'b0;
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("bp_sent", i, 300);
        bus.out_ready = 1'b1;
        wait_drain(2000);
        bus.out_ready = 1'b0;

        // ---- reset mid-stream with a read in flight ----
        for (int k = 0; k < 8; k++) push_word(DW'(9'h100 + k));
        @(negedge clk);
        check("mr_count8", count, 8);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;        // pop frees a slot -> read issued
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("mr_count7", count, 7);
        #1;
        rst = 1'b1;
        #1;
        check("mr_count0", count, 0);
        check("mr_out_valid", bus.out_valid, 0);
        check("mr_empty", empty, 1);
        check("mr_in_ready", bus.in_ready, 0);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        push_word(9'h055);
        cyc = 0;
        @(negedge clk);
        while (!bus.out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("mr_first_valid", bus.out_valid, 1);
        check("mr_first_data", bus.out_data, 9'h055);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_drain(100);
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("final_count", count, 0);
        check("final_empty", empty, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
